// File: rtl/aes_round_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// aes_round_ctrl
//
// Purpose
//   Sequencer for an iterative AES-128 encryption datapath that performs one
//   round per clock. After a start request it drives:
//     1. the initial addRoundKey (plaintext ^ cipher key),
//     2. rounds 1..NR-1 (subBytes/shiftRows/mixColumns/addRoundKey),
//     3. the final round with mixColumns bypassed.
//   It then holds the result with done asserted. The block holds no cipher
//   data. It only produces enables, mux selects, the round index and rcon.
//
// Parameters
//   NR         number of rounds, legal range 2..10 (rcon table covers 1..10)
//
// Ports
//   clk        in   1  system clock, rising edge
//   reset      in   1  asynchronous assert, active high. Release is expected
//                      to be synchronous to clk.
//   start      in   1  encryption request, honoured only in IDLE or DONE
//   round_idx  out  4  current round number (0 = initial addRoundKey)
//   rcon       out  8  key-expansion round constant for the current round
//   sel_init   out  1  state reg takes plaintext ^ key (round 0 path)
//   key_load   out  1  key reg takes the cipher key instead of the expanded key
//   skip_mix   out  1  bypass mixColumns (final round)
//   state_en   out  1  state register load enable
//   key_en     out  1  round-key register load enable
//   busy       out  1  high while INIT/ROUND/FINAL are active
//   done       out  1  ciphertext valid in the state register (level)
// -----------------------------------------------------------------------------
module aes_round_ctrl #(
  parameter int unsigned NR = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [3:0] round_idx,
  output logic [7:0] rcon,
  output logic       sel_init,
  output logic       key_load,
  output logic       skip_mix,
  output logic       state_en,
  output logic       key_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_ROUND = 3'd2,
    S_FINAL = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [3:0] FINAL_ROUND    = 4'(NR);
  localparam logic [3:0] LAST_MID_ROUND = 4'(NR - 1);

  state_t     state_reg;
  state_t     state_next;
  logic [3:0] round_reg;
  logic [3:0] round_next;

  // Round constants for rounds 1..10; anything else maps to 00.
  function automatic logic [7:0] rcon_lut(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  // State register. Reset asserts asynchronously so a mid-run abort silences
  // every enable without waiting for a clock edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= S_IDLE;
      round_reg <= 4'd0;
    end else begin
      state_reg <= state_next;
      round_reg <= round_next;
    end
  end

  // Next-state logic. The round counter is only advanced inside ROUND and is
  // loaded with NR on the way into FINAL, so it can never run past NR.
  always_comb begin
    state_next = state_reg;
    round_next = round_reg;
    case (state_reg)
      S_IDLE: begin
        round_next = 4'd0;
        if (start) begin
          state_next = S_INIT;
        end
      end
      S_INIT: begin
        state_next = S_ROUND;
        round_next = 4'd1;
      end
      S_ROUND: begin
        if (round_reg == LAST_MID_ROUND) begin
          state_next = S_FINAL;
          round_next = FINAL_ROUND;
        end else begin
          round_next = round_reg + 4'd1;
        end
      end
      S_FINAL: begin
        state_next = S_DONE;
        round_next = 4'd0;
      end
      S_DONE: begin
        round_next = 4'd0;
        // A restart goes straight to INIT; done drops on the following cycle.
        if (start) begin
          state_next = S_INIT;
        end
      end
      default: begin
        // Unreachable encodings recover to IDLE.
        state_next = S_IDLE;
        round_next = 4'd0;
      end
    endcase
  end

  // Output decode (Moore). Every output defaults to 0, which covers both
  // IDLE and any unreachable encoding.
  always_comb begin
    round_idx = 4'd0;
    rcon      = 8'h00;
    sel_init  = 1'b0;
    key_load  = 1'b0;
    skip_mix  = 1'b0;
    state_en  = 1'b0;
    key_en    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_reg)
      S_INIT: begin
        sel_init = 1'b1;
        key_load = 1'b1;
        state_en = 1'b1;
        key_en   = 1'b1;
        busy     = 1'b1;
      end
      S_ROUND: begin
        round_idx = round_reg;
        rcon      = rcon_lut(round_reg);
        state_en  = 1'b1;
        key_en    = 1'b1;
        busy      = 1'b1;
      end
      S_FINAL: begin
        round_idx = round_reg;
        rcon      = rcon_lut(round_reg);
        skip_mix  = 1'b1;
        state_en  = 1'b1;
        key_en    = 1'b1;
        busy      = 1'b1;
      end
      S_DONE: begin
        // Enables stay low so the ciphertext is held in the datapath.
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Drives aes_round_ctrl (NR=10) together with a behavioural AES datapath that
// obeys the controller's enables and selects. A second instance with NR=4
// exercises the short build. Expected runs are queued when start is issued.
// A monitor samples after each falling edge, compares the control outputs
// against a cycle-offset description of a run, and on done compares the
// datapath contents against a reference AES model.
// -----------------------------------------------------------------------------
module tb_aes_round_ctrl;

  localparam int NR  = 10;
  localparam int NR4 = 4;

  localparam logic [127:0] KAT_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KAT_PT  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] KAT_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

  localparam logic [18:0] RIDX_MASK = {4'hf, 15'h0};

  logic       clk;
  logic       reset;
  logic       start;
  logic       start4;
  logic [3:0] round_idx,  round_idx4;
  logic [7:0] rcon,       rcon4;
  logic       sel_init,   sel_init4;
  logic       key_load,   key_load4;
  logic       skip_mix,   skip_mix4;
  logic       state_en,   state_en4;
  logic       key_en,     key_en4;
  logic       busy,       busy4;
  logic       done,       done4;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  aes_round_ctrl #(.NR(NR)) u_dut (
    .clk(clk), .reset(reset), .start(start),
    .round_idx(round_idx), .rcon(rcon), .sel_init(sel_init),
    .key_load(key_load), .skip_mix(skip_mix), .state_en(state_en),
    .key_en(key_en), .busy(busy), .done(done)
  );

  aes_round_ctrl #(.NR(NR4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .round_idx(round_idx4), .rcon(rcon4), .sel_init(sel_init4),
    .key_load(key_load4), .skip_mix(skip_mix4), .state_en(state_en4),
    .key_en(key_en4), .busy(busy4), .done(done4)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // ---------------------------------------------------------------- AES model
  logic [7:0] sbox_t [256];

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p  = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = xtime(aa);
      bb = bb >> 1;
    end
    return p;
  endfunction

  // x^254 is the multiplicative inverse in GF(2^8) (and maps 0 to 0).
  function automatic logic [7:0] ginv(input logic [7:0] x);
    logic [7:0] r = 8'h01;
    for (int i = 0; i < 254; i++) r = gmul(r, x);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
             ^ {b[3:0], b[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] rc_of(input int r);
    logic [7:0] v = 8'h01;
    for (int i = 1; i < r; i++) v = xtime(v);
    return v;
  endfunction

  // Byte 0 is the most significant byte; columns are bytes 4c..4c+3.
  function automatic logic [7:0] gb(input logic [127:0] s, input int i);
    return s[127-8*i -: 8];
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sbox_t[gb(s, i)];
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = gb(s, r + 4*((c + r) % 4));
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o = '0;
    logic [7:0] a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = gb(s, 4*c); a1 = gb(s, 4*c+1); a2 = gb(s, 4*c+2); a3 = gb(s, 4*c+3);
      o[127-8*(4*c)   -: 8] = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
      o[127-8*(4*c+1) -: 8] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
      o[127-8*(4*c+2) -: 8] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
      o[127-8*(4*c+3) -: 8] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
    end
    return o;
  endfunction

  function automatic logic [127:0] expand_key(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96]; w1 = k[95:64]; w2 = k[63:32]; w3 = k[31:0];
    t  = {sbox_t[w3[23:16]], sbox_t[w3[15:8]], sbox_t[w3[7:0]], sbox_t[w3[31:24]]}
         ^ {rc, 24'h0};
    w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s = pt ^ key;
    logic [127:0] k = key;
    for (int r = 1; r <= NR; r++) begin
      k = expand_key(k, rc_of(r));
      s = shift_rows(sub_bytes(s));
      if (r != NR) s = mix_columns(s);
      s = s ^ k;
    end
    return s;
  endfunction

  // ----------------------------------------------- datapath under control
  logic [127:0] dp_state, dp_key, dp_pt, dp_key_in;

  always @(posedge clk) begin
    if (state_en)
      dp_state <= sel_init ? (dp_pt ^ dp_key_in)
                : ((skip_mix ? shift_rows(sub_bytes(dp_state))
                             : mix_columns(shift_rows(sub_bytes(dp_state))))
                   ^ expand_key(dp_key, rcon));
    if (key_en)
      dp_key <= key_load ? dp_key_in : expand_key(dp_key, rcon);
  end

  // ----------------------------------------------------------- scoreboard
  typedef struct {
    int           c0;   // cycle number in which INIT is visible
    logic [127:0] ct;
  } run_t;

  run_t exp_q[$];

  // Control outputs expected k cycles after INIT became visible.
  // Packing: {round_idx, rcon, sel_init, key_load, skip_mix, state_en, key_en, busy, done}
  function automatic logic [18:0] exp_ctrl(input int k);
    logic [3:0] ri = 4'd0;
    logic [7:0] rc = 8'h00;
    logic si = 1'b0, kl = 1'b0, sm = 1'b0, se = 1'b0, ke = 1'b0, bs = 1'b0, dn = 1'b0;
    if (k == 0) begin
      si = 1'b1; kl = 1'b1; se = 1'b1; ke = 1'b1; bs = 1'b1;
    end else if (k <= NR) begin
      ri = 4'(k); rc = rc_of(k); sm = (k == NR); se = 1'b1; ke = 1'b1; bs = 1'b1;
    end else begin
      dn = 1'b1;
    end
    return {ri, rc, si, kl, sm, se, ke, bs, dn};
  endfunction

  task automatic check_ctrl(input string name, input logic [18:0] a,
                            input logic [18:0] e, input logic [18:0] m);
    checks++;
    if ((a & ~m) !== (e & ~m)) begin
      failures++;
      $display("FAIL %s cyc=%0d ctrl actual=%05h required=%05h (mask %05h)", name, cyc, a, e, m);
    end
  endtask

  task automatic check_val(input string name, input logic [127:0] a, input logic [127:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, a, e);
    end
  endtask

  logic [18:0]  act;
  int           k;
  bit           held = 1'b0;
  logic [127:0] held_ct;

  // Monitor: one sample per cycle, after the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      act = {round_idx, rcon, sel_init, key_load, skip_mix, state_en, key_en, busy, done};
      if (reset) begin
        held = 1'b0;
        check_ctrl("reset_outputs", act, 19'h0, 19'h0);
      end else if (exp_q.size() > 0 && cyc >= exp_q[0].c0) begin
        held = 1'b0;
        k = cyc - exp_q[0].c0;
        check_ctrl($sformatf("run_k%0d", k), act, exp_ctrl(k), (k > NR) ? RIDX_MASK : 19'h0);
        if (done) begin
          check_val("done_latency", 128'(k), 128'(NR + 1));
          check_val("ciphertext", dp_state, exp_q[0].ct);
          $display("run c0=%0d done at k=%0d ct=%h", exp_q[0].c0, k, dp_state);
          held    = 1'b1;
          held_ct = exp_q[0].ct;
          void'(exp_q.pop_front());
        end else if (k > NR + 1) begin
          failures++;
          checks++;
          $display("FAIL done_timeout cyc=%0d actual=done_low required=done_at_k%0d", cyc, NR + 1);
          void'(exp_q.pop_front());
        end
      end else if (held) begin
        check_ctrl("done_hold", act, exp_ctrl(NR + 1), RIDX_MASK);
        check_val("ct_hold", dp_state, held_ct);
      end else begin
        check_ctrl("idle", act, 19'h0, 19'h0);
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Issues a one-cycle start pulse from IDLE/DONE and queues the expected run.
  task automatic launch(input logic [127:0] key, input logic [127:0] pt,
                        input logic [127:0] ct, output int c0);
    @(negedge clk);
    dp_key_in = key;
    dp_pt     = pt;
    start     = 1'b1;
    c0        = cyc + 1;
    exp_q.push_back('{c0, ct});
    @(negedge clk);
    start = 1'b0;
  endtask

  int           c0;
  logic [127:0] rk, rp, rk2, rp2;

  initial begin
    for (int i = 0; i < 256; i++) sbox_t[i] = affine(ginv(8'(i)));
    reset     = 1'b1;
    start     = 1'b0;
    start4    = 1'b0;
    dp_pt     = '0;
    dp_key_in = '0;

    // Reset, then idle: monitor expects all-zero outputs.
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Known-answer run; the NR=4 instance is started in the same cycle.
    @(negedge clk);
    dp_key_in = KAT_KEY;
    dp_pt     = KAT_PT;
    start     = 1'b1;
    start4    = 1'b1;
    c0        = cyc + 1;
    exp_q.push_back('{c0, KAT_CT});
    @(negedge clk);
    start  = 1'b0;
    start4 = 1'b0;
    wait_until(c0 + NR4);
    #1;
    check_val("nr4_final_round", {round_idx4, done4, busy4, skip_mix4, state_en4, key_en4},
              {4'd4, 5'b01111});
    wait_until(c0 + NR4 + 1);
    #1;
    check_val("nr4_done", {done4, busy4, skip_mix4, state_en4, key_en4}, 5'b10000);
    wait_until(c0 + NR + 3);

    // start re-pulsed in rounds 3 and 7 is ignored.
    launch(KAT_KEY, KAT_PT, KAT_CT, c0);
    wait_until(c0 + 3);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(c0 + 7);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_until(c0 + NR + 4);

    // Reset during round 5, then a clean rerun.
    launch(KAT_KEY, KAT_PT, KAT_CT, c0);
    wait_until(c0 + 5);
    reset = 1'b1;
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    launch(KAT_KEY, KAT_PT, KAT_CT, c0);
    wait_until(c0 + NR + 3);

    // start held high through DONE: two back-to-back runs.
    rk  = {$urandom, $urandom, $urandom, $urandom};
    rp  = {$urandom, $urandom, $urandom, $urandom};
    rk2 = {$urandom, $urandom, $urandom, $urandom};
    rp2 = {$urandom, $urandom, $urandom, $urandom};
    @(negedge clk);
    dp_key_in = rk;
    dp_pt     = rp;
    start     = 1'b1;
    c0        = cyc + 1;
    exp_q.push_back('{c0, aes_ref(rk, rp)});
    exp_q.push_back('{c0 + NR + 2, aes_ref(rk2, rp2)});
    wait_until(c0 + 1);
    dp_key_in = rk2;
    dp_pt     = rp2;
    wait_until(c0 + NR + 3);
    start = 1'b0;
    wait_until(c0 + 2 * NR + 6);

    // Random runs with random gaps and optional ignored start pulses.
    for (int n = 0; n < 8; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      rk = {$urandom, $urandom, $urandom, $urandom};
      rp = {$urandom, $urandom, $urandom, $urandom};
      launch(rk, rp, aes_ref(rk, rp), c0);
      if ($urandom_range(0, 1) == 1) begin
        wait_until(c0 + int'($urandom_range(0, NR)));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      wait_until(c0 + NR + 2);
    end

    repeat (4) @(negedge clk);
    check_val("queue_drained", 128'(exp_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
